byte_packer: RTL and testbench
==============================

# byte_packer

Downstream consumer of the 8-bit `data_out` stream from `b`. Packs consecutive bytes into BYTES-wide words and presents them on a valid/ready output with a per-byte keep mask. A `flush` request emits a partially filled word. A single output holding register decouples assembly from downstream stalls, so full byte-rate throughput is sustained while `out_ready` is high.

## Interface
- `BYTES`, default 4: bytes per output word; legal range 2..8.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  `data_in` carries a byte this cycle.
- `in_ready`  out  1  byte is accepted when `in_valid && in_ready`.
- `data_in`  in  8  byte from `b.data_out`.
- `flush`  in  1  one-cycle request to emit the partial word.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  downstream accepts; transfer when `out_valid && out_ready`.
- `data_out`  out  8*BYTES  packed word.
- `out_keep`  out  BYTES  bit i set means byte lane i holds data.

## Operation
- **State**
  - Assembly register `asm[8*BYTES-1:0]`.
  - Lane index `idx`, range 0..BYTES-1.
  - Output register: `data_out`, `out_keep`, `out_valid`.
  - `flush_pend` flag.
- **Lane order:** the first accepted byte goes to lane 0, `data_out[7:0]`. The k-th accepted byte goes to lane k (little-endian).
- **Byte accept:** write `data_in` into lane `idx`, then `idx <= idx+1`.
- **Word completion:** on accepting a byte with `idx == BYTES-1`:
  - the output register loads `{data_in, asm[lower lanes]}`;
  - `out_keep` = all ones;
  - `out_valid` = 1;
  - `idx` = 0.
- **Slot free:** the output register can load when `out_valid == 0` or `out_ready == 1` in the same cycle.
- **`in_ready`:** combinational; `in_ready = !flush_pend && !(idx == BYTES-1 && out_valid && !out_ready)`.
- **Flush**
  - `flush` sets `flush_pend` if `idx > 0` after including any byte accepted in the same cycle.
  - If the slot is free, emit immediately: the output register loads `asm` (including the same-cycle byte), `out_keep` = low `idx'` bits set (`idx'` = post-accept count), `idx` = 0, `flush_pend` = 0.
  - Otherwise `flush_pend` holds, and the emit happens on the first cycle the slot frees.
  - Flush with `idx == 0` and no accepted byte is a no-op, with no empty word.
  - Flush on the same cycle as word completion: the completed full word is emitted and nothing further happens.
  - A second `flush` while `flush_pend` is set is absorbed.
- **Unused lanes:** `data_out` lanes not covered by `out_keep` are 0; `asm` is cleared on each emit.
- **Transfer without reload:** on `out_valid && out_ready` with no new load, `out_valid` = 0; `data_out` and `out_keep` hold their values.
- **Stability under stall:** while `out_valid && !out_ready`, `data_out` and `out_keep` must not change.

## Timing
- **Reset values:** `out_valid` = 0, `data_out` = 0, `out_keep` = 0, `idx` = 0, `flush_pend` = 0, `asm` = 0. `in_ready` = 1 on the first cycle after reset deasserts.
- **Reset mid-operation:** reset discards the partial word and any pending flush; nothing is emitted.
- **Latency:** the last byte is accepted at edge N; `out_valid` is high from edge N through the next downstream handshake, i.e. visible in cycle N+1.
- **Flush latency:** flush at edge N with the slot free gives `out_valid` in cycle N+1.
- **Throughput:** one byte per cycle and one word per BYTES cycles with `out_ready` held high, with no bubbles.
- **Back-to-back reload:** a word may be loaded in the same cycle the previous one transfers.
- **`in_ready` stall:** low only on the last lane while the output is blocked, or while a flush is pending. Earlier lanes keep accepting under downstream stall.
- **Combinational path:** `out_ready` → `in_ready` is the only one; there is no path from `in_valid`.

## Test plan
- **Sustained packing:** BYTES=4, `out_ready`=1, stream 0x01..0x08 on consecutive cycles. Expect `data_out` = 0x04030201 with keep 0xF, then 0x08070605 one BYTES period later; `in_ready` stays 1.
- **Output stall:** hold `out_ready`=0 while feeding 0x10..0x17. Expect:
  - the first word 0x13121110 holds stable;
  - 0x14..0x16 are accepted;
  - `in_ready` drops with `idx`=3;
  - after `out_ready`=1, 0x17 is accepted next cycle and word 0x17161514 follows.
- **Partial flush:** feed 0xAA, 0xBB, then pulse `flush`. Expect `data_out` = 0x0000BBAA, keep 0x3, one cycle later. Flush with `idx`=0 produces no word.
- **Flush with same-cycle byte:** pulse `flush` on the same cycle as the third byte 0xCC after 0xAA, 0xBB. Expect word 0x00CCBBAA, keep 0x7.
- **Pending flush:** pulse `flush` while the output is blocked with 2 bytes held. Expect:
  - `in_ready`=0 until `out_ready` rises;
  - the partial word is emitted the cycle after the prior word transfers.
- **Reset mid-word:** assert `rst` after 2 bytes. Expect all outputs at reset values and the next 4 bytes forming a clean word starting at lane 0.

Source files
------------

// File: rtl/byte_packer.sv
// byte_packer
// Packs a stream of bytes into BYTES-wide words, little-endian by arrival
// order (the first byte of a word lands in lane 0). A flush request emits a
// partially filled word. Unused lanes read as zero and are flagged by the
// out_keep mask. A single output holding register lets the next word
// assemble while the previous one waits for the downstream consumer.
//
// Handshakes (both sides): a transfer happens on a rising edge where
// valid && ready. A producer holds valid and its payload stable until the
// transfer. The ready signal never depends on the valid signal of the same
// port.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   data_in carries a byte this cycle
//   in_ready   byte accepted when in_valid && in_ready (combinational from out_ready)
//   data_in    input byte
//   flush      one-cycle request to emit the partial word
//   out_valid  data_out / out_keep hold a word
//   out_ready  downstream accepts the word
//   data_out   packed word, lane i = data_out[8*i +: 8]
//   out_keep   bit i set when lane i holds data
module byte_packer #(
    parameter int BYTES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           data_in,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*BYTES-1:0]   data_out,
    output logic [BYTES-1:0]     out_keep
);

    localparam int IW = $clog2(BYTES);
    // Count width holds 0..BYTES, one more than the lane index needs.
    localparam int CW = IW + 1;
    localparam logic [IW-1:0] LAST = IW'(BYTES - 1);

    logic [8*BYTES-1:0] asm_q;
    logic [8*BYTES-1:0] asm_next;
    logic [IW-1:0]      idx;
    logic               flush_pend;

    logic [CW-1:0]      count_next;
    logic               slot_free;
    logic               accept;
    logic               complete;
    logic               flush_req;
    logic               emit_partial;
    logic               set_pend;
    logic [BYTES-1:0]   keep_partial;

    always_comb begin
        slot_free = !out_valid || out_ready;
        // Only the last lane has to wait for the holding register; earlier
        // lanes keep filling the assembly register under a downstream stall.
        in_ready  = !flush_pend && !(idx == LAST && out_valid && !out_ready);
        accept    = in_valid && in_ready;
        complete  = accept && (idx == LAST);

        // Byte count after this cycle's accept, so a flush arriving with a
        // byte includes that byte.
        count_next = {1'b0, idx} + CW'(accept);

        asm_next = asm_q;
        for (int i = 0; i < BYTES; i++) begin
            if (accept && idx == IW'(i)) begin
                asm_next[8*i +: 8] = data_in;
            end
        end

        // A completing word takes priority; it already empties the assembly
        // register, so a simultaneous flush has nothing left to emit.
        flush_req    = (flush || flush_pend) && (count_next != '0) && !complete;
        emit_partial = flush_req && slot_free;
        set_pend     = flush_req && !slot_free;

        keep_partial = '0;
        for (int i = 0; i < BYTES; i++) begin
            keep_partial[i] = (CW'(i) < count_next);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q      <= '0;
            idx        <= '0;
            flush_pend <= 1'b0;
            out_valid  <= 1'b0;
            data_out   <= '0;
            out_keep   <= '0;
        end else if (complete) begin
            // in_ready guarantees the slot is free whenever a word completes.
            data_out   <= asm_next;
            out_keep   <= '1;
            out_valid  <= 1'b1;
            asm_q      <= '0;
            idx        <= '0;
            flush_pend <= 1'b0;
        end else if (emit_partial) begin
            // asm is cleared on every emit, so lanes beyond the count are 0.
            data_out   <= asm_next;
            out_keep   <= keep_partial;
            out_valid  <= 1'b1;
            asm_q      <= '0;
            idx        <= '0;
            flush_pend <= 1'b0;
        end else begin
            // Transfer without reload: drop valid, keep the payload.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            asm_q <= asm_next;
            idx   <= count_next[IW-1:0];
            if (set_pend) begin
                flush_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_byte_packer.sv
module tb_byte_packer;

  localparam int B = 4;
  localparam int DW = 8 * B;
  localparam int W = DW + B;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    data_in;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] data_out;
  logic [B-1:0]  out_keep;

  int checks = 0;
  int errors = 0;

  // Reference model: bytes waiting to form a word, the word the output
  // register should hold, and whether a flush is waiting for the slot.
  logic [7:0]    part[$];
  bit            m_hold_v;
  logic [DW-1:0] m_data;
  logic [B-1:0]  m_keep;
  bit            m_pend;
  logic [W-1:0]  exp_q[$];

  byte_packer #(.BYTES(B)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data_in(data_in),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out(data_out),
    .out_keep(out_keep)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word from the queued bytes: byte k in lane k, missing lanes zero.
  task automatic model_load();
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < part.size(); i++) w[8*i +: 8] = part[i];
    m_data = w;
    m_keep = B'((1 << part.size()) - 1);
    m_hold_v = 1'b1;
    exp_q.push_back({m_keep, m_data});
    part.delete();
  endtask

  task automatic model_reset();
    part.delete();
    exp_q.delete();
    m_hold_v = 1'b0;
    m_data = '0;
    m_keep = '0;
    m_pend = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    data_in = 8'h00;
    flush = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive inputs, compare outputs mid-cycle, advance model.
  task automatic step(input bit iv, input logic [7:0] d, input bit fl, input bit ordy);
    bit m_in_ready;
    bit m_slot_free;
    bit acc;
    logic [W-1:0] w;
    in_valid = iv;
    data_in = d;
    flush = fl;
    out_ready = ordy;
    @(negedge clk);
    m_slot_free = !m_hold_v || ordy;
    m_in_ready = !m_pend && !(part.size() == B - 1 && m_hold_v && !ordy);
    chk("in_ready", 64'(in_ready), 64'(m_in_ready));
    chk("out_valid", 64'(out_valid), 64'(m_hold_v));
    chk("data_out", 64'(data_out), 64'(m_data));
    chk("out_keep", 64'(out_keep), 64'(m_keep));
    if (m_hold_v && ordy) begin
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        chk("sb_word", 64'({out_keep, data_out}), 64'(w));
      end
      m_hold_v = 1'b0;
    end
    acc = iv && m_in_ready;
    if (acc) part.push_back(d);
    if (acc && part.size() == B) begin
      model_load();
    end else if ((fl || m_pend) && part.size() > 0) begin
      if (m_slot_free) begin
        model_load();
        m_pend = 1'b0;
      end else begin
        m_pend = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_data_out", 64'(data_out), 64'd0);
    chk("rst_out_keep", 64'(out_keep), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Sustained packing at full rate.
    for (int k = 1; k <= 4; k++) step(1'b1, 8'(k), 1'b0, 1'b1);
    chk("pack_w0", 64'(data_out), 64'h04030201);
    chk("pack_k0", 64'(out_keep), 64'hF);
    for (int k = 5; k <= 8; k++) step(1'b1, 8'(k), 1'b0, 1'b1);
    chk("pack_w1", 64'(data_out), 64'h08070605);
    chk("pack_v1", 64'(out_valid), 64'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Output stall.
    for (int k = 'h10; k <= 'h16; k++) step(1'b1, 8'(k), 1'b0, 1'b0);
    step(1'b1, 8'h17, 1'b0, 1'b0);
    step(1'b1, 8'h17, 1'b0, 1'b0);
    chk("stall_hold", 64'(data_out), 64'h13121110);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    step(1'b1, 8'h17, 1'b0, 1'b1);
    chk("stall_w1", 64'(data_out), 64'h17161514);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Partial flush, then flush with nothing assembled.
    step(1'b1, 8'hAA, 1'b0, 1'b1);
    step(1'b1, 8'hBB, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("flush_data", 64'(data_out), 64'h0000BBAA);
    chk("flush_keep", 64'(out_keep), 64'h3);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("flush_empty_valid", 64'(out_valid), 64'd0);

    // Flush on the same cycle as a byte.
    step(1'b1, 8'hAA, 1'b0, 1'b1);
    step(1'b1, 8'hBB, 1'b0, 1'b1);
    step(1'b1, 8'hCC, 1'b1, 1'b1);
    chk("flush_same_data", 64'(data_out), 64'h00CCBBAA);
    chk("flush_same_keep", 64'(out_keep), 64'h7);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Pending flush behind a blocked word.
    for (int k = 'h20; k <= 'h25; k++) step(1'b1, 8'(k), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h26, 1'b0, 1'b0);
    step(1'b1, 8'h26, 1'b1, 1'b0);
    chk("pend_in_ready", 64'(in_ready), 64'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("pend_data", 64'(data_out), 64'h00002524);
    chk("pend_keep", 64'(out_keep), 64'h3);
    chk("pend_valid", 64'(out_valid), 64'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Reset mid-word.
    step(1'b1, 8'h30, 1'b0, 1'b1);
    step(1'b1, 8'h31, 1'b0, 1'b1);
    do_reset();
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_data", 64'(data_out), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    for (int k = 'h40; k <= 'h43; k++) step(1'b1, 8'(k), 1'b0, 1'b1);
    chk("midrst_word", 64'(data_out), 64'h43424140);
    chk("midrst_keep", 64'(out_keep), 64'hF);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) == 0,
             $urandom_range(0, 9) < 7);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
